// File: rtl/dma_burst_read_engine_if.sv
// c0 read-channel bundle between the burst read engine (master) and the
// MPF-wrapped memory side (slave): request header, back-pressure, responses.
interface dma_burst_read_engine_if;
  logic         tx_valid;
  logic [1:0]   tx_vc_sel;
  logic [3:0]   tx_req_type;
  logic [1:0]   tx_cl_len;
  logic [41:0]  tx_address;
  logic [15:0]  tx_mdata;
  logic         tx_alm_full;
  logic         rx_rsp_valid;
  logic [15:0]  rx_mdata;
  logic [511:0] rx_data;

  modport master (
    output tx_valid, tx_vc_sel, tx_req_type, tx_cl_len, tx_address, tx_mdata,
    input  tx_alm_full, rx_rsp_valid, rx_mdata, rx_data
  );

  modport slave (
    input  tx_valid, tx_vc_sel, tx_req_type, tx_cl_len, tx_address, tx_mdata,
    output tx_alm_full, rx_rsp_valid, rx_mdata, rx_data
  );
endinterface

// File: rtl/dma_burst_read_engine.sv
// Burst DMA read engine: streams a latched job of cache lines from the c0 read
// channel in order, with a credit limit on lines in flight and epoch-based drop/rewind.
module dma_burst_read_engine #(
  parameter int unsigned BURST           = 4,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned EPOCH_W         = 8,
  parameter int unsigned CNT_W           = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [41:0]             src_addr,
  input  logic [31:0]             src_ncl,
  input  logic                    start,
  input  logic                    drop,
  dma_burst_read_engine_if.master c0,
  output logic [511:0]            out,
  output logic                    out_valid,
  output logic                    done,
  output logic                    busy,
  output logic [CNT_W-1:0]        outstanding
);

  localparam int unsigned CW1          = CNT_W + 1;
  localparam logic [1:0]  BURST_MASK   = 2'(BURST - 1);
  localparam logic [1:0]  VC_VA        = 2'h0;
  localparam logic [3:0]  REQ_RDLINE_S = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DROP,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [41:0]        addr_q, addr_d;
  logic [31:0]        ncl_q, ncl_d;
  logic [31:0]        req_idx_q, req_idx_d;
  logic [31:0]        rsp_idx_q, rsp_idx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               tx_valid_q, tx_valid_d;
  logic [1:0]         tx_cl_len_q, tx_cl_len_d;
  logic [41:0]        tx_address_q, tx_address_d;
  logic [15:0]        tx_mdata_q, tx_mdata_d;
  logic [511:0]       out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [41:0]        cur_addr;
  logic [31:0]        remaining;
  logic               aligned;
  logic [2:0]         len;
  logic [CW1-1:0]     credit_need;
  logic               issue;
  logic               accept;
  logic [CNT_W-1:0]   cnt_sum;

  // Request sizing: a full burst only from a BURST-aligned line with enough lines left.
  always_comb begin
    cur_addr    = addr_q + 42'(req_idx_q);
    remaining   = ncl_q - req_idx_q;
    aligned     = (cur_addr[1:0] & BURST_MASK) == 2'b00;
    len         = (aligned && (remaining >= 32'(BURST))) ? 3'(BURST) : 3'd1;
    credit_need = {1'b0, outstanding_q} + CW1'(len);
    issue       = (state_q == S_RUN) && !c0.tx_alm_full && (req_idx_q < ncl_q) &&
                  (credit_need <= CW1'(MAX_OUTSTANDING));
    accept      = c0.rx_rsp_valid && (c0.rx_mdata == 16'(epoch_q)) &&
                  ((state_q == S_RUN) || (state_q == S_WAIT));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN: begin
        if (drop)                        state_d = S_DROP;
        else if (req_idx_q == ncl_q)     state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_idx_q == ncl_q)          state_d = S_FINISH;
        else if (drop)                   state_d = S_DROP;
      end
      S_DROP:   if (!drop) state_d = S_RUN;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Every response returns a credit regardless of epoch; saturating at zero keeps
  // responses to requests abandoned by a reset from wrapping the counter.
  always_comb begin
    cnt_sum = outstanding_q;
    if (issue) cnt_sum = cnt_sum + CNT_W'(len);
    if (c0.rx_rsp_valid && (cnt_sum != '0)) cnt_sum = cnt_sum - CNT_W'(1);
    outstanding_d = cnt_sum;
  end

  always_comb begin
    addr_d    = addr_q;
    ncl_d     = ncl_q;
    req_idx_d = req_idx_q;
    rsp_idx_d = rsp_idx_q;
    epoch_d   = epoch_q;

    if ((state_q == S_IDLE) && start) begin
      addr_d    = src_addr;
      ncl_d     = src_ncl;
      req_idx_d = '0;
      rsp_idx_d = '0;
    end
    if (issue)  req_idx_d = req_idx_q + 32'(len);
    if (accept) rsp_idx_d = rsp_idx_q + 32'd1;
    if (state_q == S_DROP) req_idx_d = rsp_idx_q;
    // A new epoch is only needed when stale lines can still come back.
    if ((state_d == S_DROP) && (state_q != S_DROP) && (outstanding_d != '0))
      epoch_d = epoch_q + EPOCH_W'(1);

    tx_valid_d   = issue;
    tx_cl_len_d  = 2'(len - 3'd1);
    tx_address_d = cur_addr;
    tx_mdata_d   = 16'(epoch_q);

    out_valid_d  = accept;
    out_d        = accept ? c0.rx_data : out_q;
    done_d       = (state_q == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      ncl_q         <= '0;
      req_idx_q     <= '0;
      rsp_idx_q     <= '0;
      epoch_q       <= '0;
      outstanding_q <= '0;
      tx_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ncl_q         <= ncl_d;
      req_idx_q     <= req_idx_d;
      rsp_idx_q     <= rsp_idx_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      tx_valid_q    <= tx_valid_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_cl_len_q  <= tx_cl_len_d;
    tx_address_q <= tx_address_d;
    tx_mdata_q   <= tx_mdata_d;
    out_q        <= out_d;
  end

  assign c0.tx_valid    = tx_valid_q;
  assign c0.tx_vc_sel   = VC_VA;
  assign c0.tx_req_type = REQ_RDLINE_S;
  assign c0.tx_cl_len   = tx_cl_len_q;
  assign c0.tx_address  = tx_address_q;
  assign c0.tx_mdata    = tx_mdata_q;

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign outstanding = outstanding_q;

endmodule
